// File: rtl/io_dev_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : Shared code width, FSM state indices and well-known I/O codes.
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;
  localparam int CODE_W = 5;

  // Bit positions of the one-hot TX/RX state vectors
  localparam int TX_IDLE_B = 0;
  localparam int TX_RDY_B  = 1;
  localparam int TX_WAIT_B = 2;
  localparam int TX_PACE_B = 3;
  localparam int RX_IDLE_B = 0;
  localparam int RX_ACK_B  = 1;
  localparam int RX_PACE_B = 2;

  localparam logic [CODE_W-1:0] C_CODE_NUM_PREFIX = 5'b10000;
  localparam logic [CODE_W-1:0] C_CODE_WRITE      = 5'b00110;
  localparam logic [CODE_W-1:0] C_CODE_END        = 5'b00111;
  localparam logic [CODE_W-1:0] C_CODE_SELECT     = 5'b00001;
endpackage
`default_nettype wire

// File: rtl/io_dev_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : io_dev_bridge_if
// Purpose  : Host stream, I/O unit rdy/ack channels and panel signals.
// Revision : 1.0 - initial release
// ============================================================================
interface io_dev_bridge_if #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
);
  import io_pkg::*;

  localparam int IN_LW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_LW = $clog2(OUT_DEPTH) + 1;

  logic              host_in_valid_from_host;
  logic              host_in_ready_to_host;
  logic [CODE_W-1:0] host_in_data_from_host;
  logic              host_out_valid_to_host;
  logic              host_out_ready_from_host;
  logic [CODE_W-1:0] host_out_data_to_host;
  logic              input_rdy_to_io;
  logic              input_ack_from_io;
  logic [CODE_W-1:0] input_data_to_io;
  logic              output_rdy_from_io;
  logic              output_ack_to_io;
  logic [CODE_W-1:0] output_data_from_io;
  logic              flush_from_pnl;
  logic [IN_LW-1:0]  in_level_to_pnl;
  logic [OUT_LW-1:0] out_level_to_pnl;

  modport master (
    output host_in_valid_from_host, host_in_data_from_host, host_out_ready_from_host,
    output input_ack_from_io, output_rdy_from_io, output_data_from_io, flush_from_pnl,
    input  host_in_ready_to_host, host_out_valid_to_host, host_out_data_to_host,
    input  input_rdy_to_io, input_data_to_io, output_ack_to_io,
    input  in_level_to_pnl, out_level_to_pnl
  );

  modport slave (
    input  host_in_valid_from_host, host_in_data_from_host, host_out_ready_from_host,
    input  input_ack_from_io, output_rdy_from_io, output_data_from_io, flush_from_pnl,
    output host_in_ready_to_host, host_out_valid_to_host, host_out_data_to_host,
    output input_rdy_to_io, input_data_to_io, output_ack_to_io,
    output in_level_to_pnl, out_level_to_pnl
  );
endinterface
`default_nettype wire

// File: rtl/io_dev_bridge_fifo.sv
`default_nettype none
// ============================================================================
// Module   : io_code_fifo
// Purpose  : Small code FIFO with flush; full refuses push, no pass-through.
// Revision : 1.0 - initial release
// ============================================================================
module io_code_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic                      clk,
  input  wire logic                      resetn,
  input  wire logic                      flush,
  input  wire logic                      push_valid,
  output logic                           push_ready,
  input  wire logic [CODE_W-1:0]         push_data,
  output logic                           pop_valid,
  input  wire logic                      pop_ready,
  output logic [CODE_W-1:0]              pop_data,
  output logic [$clog2(DEPTH):0]         level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic [CODE_W-1:0] r_mem [DEPTH];
  logic              r_live;
  logic              w_push;
  logic              w_pop;
  logic              w_full;

  assign level      = r_wr - r_rd;
  assign w_full     = (level == (AW+1)'(DEPTH));
  assign pop_valid  = (r_wr != r_rd);
  // r_live holds ready low through reset and for the first cycle after it
  assign push_ready = r_live && !w_full;
  assign w_push     = push_valid && push_ready && !flush;
  assign w_pop      = pop_ready && pop_valid && !flush;
  assign pop_data   = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_live <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_live <= 1'b1;
      if (flush) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wr[AW-1:0]] <= push_data;
          r_wr                <= r_wr + 1'b1;
        end
        if (w_pop) r_rd <= r_rd + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/io_dev_bridge.sv
`default_nettype none
// ============================================================================
// Module   : io_dev_bridge
// Purpose  : Tape reader/punch emulation on the I/O unit rdy/ack channels.
//            Define IO_PACE_EN to add PACE_CYCLES gaps after each character.
// Revision : 1.0 - initial release
// ============================================================================
module io_dev_bridge
  import io_pkg::*;
#(
  parameter int IN_DEPTH    = 4,
  parameter int OUT_DEPTH   = 4,
  parameter int PACE_CYCLES = 16
) (
  input  wire logic        clk,
  input  wire logic        resetn,
  io_dev_bridge_if.slave   bus
);
`ifdef IO_PACE_EN
  localparam int TX_N = 4;
  localparam int RX_N = 3;
  localparam int PCW  = $clog2(PACE_CYCLES) + 1;
  localparam logic [TX_N-1:0] TX_PACE = TX_N'(1 << TX_PACE_B);
  localparam logic [RX_N-1:0] RX_PACE = RX_N'(1 << RX_PACE_B);
`else
  localparam int TX_N = 3;
  localparam int RX_N = 2;
`endif
  localparam logic [TX_N-1:0] TX_IDLE = TX_N'(1 << TX_IDLE_B);
  localparam logic [TX_N-1:0] TX_RDY  = TX_N'(1 << TX_RDY_B);
  localparam logic [TX_N-1:0] TX_WAIT = TX_N'(1 << TX_WAIT_B);
  localparam logic [RX_N-1:0] RX_IDLE = RX_N'(1 << RX_IDLE_B);
  localparam logic [RX_N-1:0] RX_ACK  = RX_N'(1 << RX_ACK_B);

  logic [TX_N-1:0]   r_tx_state;
  logic [RX_N-1:0]   r_rx_state;
  logic [CODE_W-1:0] r_hold;
  logic              w_in_nempty;
  logic [CODE_W-1:0] w_in_head;
  logic              w_in_pop;
  logic              w_out_can_push;
  logic              w_out_push;

  // Flush must also block the load, otherwise the holding register takes a dropped code
  assign w_in_pop   = (r_tx_state == TX_IDLE) && w_in_nempty &&
                      !bus.input_ack_from_io && !bus.flush_from_pnl;
  assign w_out_push = (r_rx_state == RX_IDLE) && bus.output_rdy_from_io && w_out_can_push;

  io_code_fifo #(.DEPTH(IN_DEPTH)) u_in_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (bus.flush_from_pnl),
    .push_valid (bus.host_in_valid_from_host),
    .push_ready (bus.host_in_ready_to_host),
    .push_data  (bus.host_in_data_from_host),
    .pop_valid  (w_in_nempty),
    .pop_ready  (w_in_pop),
    .pop_data   (w_in_head),
    .level      (bus.in_level_to_pnl)
  );

  io_code_fifo #(.DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (bus.flush_from_pnl),
    .push_valid (w_out_push),
    .push_ready (w_out_can_push),
    .push_data  (bus.output_data_from_io),
    .pop_valid  (bus.host_out_valid_to_host),
    .pop_ready  (bus.host_out_ready_from_host),
    .pop_data   (bus.host_out_data_to_host),
    .level      (bus.out_level_to_pnl)
  );

`ifdef IO_PACE_EN
  logic [PCW-1:0] r_tx_cnt;
  logic [PCW-1:0] r_rx_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx_state <= TX_IDLE;
      r_hold     <= '0;
`ifdef IO_PACE_EN
      r_tx_cnt   <= '0;
`endif
    end else begin
      case (r_tx_state)
        TX_IDLE: if (w_in_pop) begin
          r_hold     <= w_in_head;
          r_tx_state <= TX_RDY;
        end
        TX_RDY:  if (bus.input_ack_from_io) r_tx_state <= TX_WAIT;
        TX_WAIT: if (!bus.input_ack_from_io) begin
`ifdef IO_PACE_EN
          r_tx_state <= TX_PACE;
          r_tx_cnt   <= '0;
`else
          r_tx_state <= TX_IDLE;
`endif
        end
`ifdef IO_PACE_EN
        TX_PACE: begin
          if (r_tx_cnt == PCW'(PACE_CYCLES - 1)) r_tx_state <= TX_IDLE;
          else                                    r_tx_cnt   <= r_tx_cnt + 1'b1;
        end
`endif
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_state <= RX_IDLE;
`ifdef IO_PACE_EN
      r_rx_cnt   <= '0;
`endif
    end else begin
      case (r_rx_state)
        RX_IDLE: if (w_out_push) r_rx_state <= RX_ACK;
        RX_ACK:  if (!bus.output_rdy_from_io) begin
`ifdef IO_PACE_EN
          r_rx_state <= RX_PACE;
          r_rx_cnt   <= '0;
`else
          r_rx_state <= RX_IDLE;
`endif
        end
`ifdef IO_PACE_EN
        RX_PACE: begin
          if (r_rx_cnt == PCW'(PACE_CYCLES - 1)) r_rx_state <= RX_IDLE;
          else                                    r_rx_cnt   <= r_rx_cnt + 1'b1;
        end
`endif
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.input_rdy_to_io  = (r_tx_state == TX_RDY);
  assign bus.input_data_to_io = r_hold;
  assign bus.output_ack_to_io = (r_rx_state == RX_ACK);
endmodule
`default_nettype wire

// File: tb/tb_io_dev_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_dev_bridge
// Purpose  : Directed self-checking bench for io_dev_bridge (depths 4/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_dev_bridge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef IO_PACE_EN
  localparam int PACE_EXTRA = 16;
`else
  localparam int PACE_EXTRA = 0;
`endif

  always #5 clk = ~clk;

  io_dev_bridge_if #(.IN_DEPTH(4), .OUT_DEPTH(4)) bus ();

  io_dev_bridge #(.IN_DEPTH(4), .OUT_DEPTH(4), .PACE_CYCLES(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic io_send(input logic [4:0] code, input logic exp_ack);
    bus.output_rdy_from_io  = 1'b1;
    bus.output_data_from_io = code;
    tick();
    chk("io_send_ack", bus.output_ack_to_io, exp_ack);
  endtask

  task automatic host_pop(input string tag, input logic [4:0] code);
    chk(tag, bus.host_out_data_to_host, code);
    chk("host_out_valid", bus.host_out_valid_to_host, 1'b1);
    bus.host_out_ready_from_host = 1'b1;
    tick();
    bus.host_out_ready_from_host = 1'b0;
  endtask

  task automatic host_push(input logic [4:0] code);
    bus.host_in_valid_from_host = 1'b1;
    bus.host_in_data_from_host  = code;
    tick();
    bus.host_in_valid_from_host = 1'b0;
  endtask

  initial begin
    logic [4:0] in_codes [5]  = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05};
    logic [4:0] out_codes [8] = '{5'b11110, 5'b10101, 5'b01010, 5'b11111,
                                  5'b00111, 5'b10000, 5'b00001, 5'b00110};
    int n;

    bus.host_in_valid_from_host  = 1'b0;
    bus.host_in_data_from_host   = '0;
    bus.host_out_ready_from_host = 1'b0;
    bus.input_ack_from_io        = 1'b0;
    bus.output_rdy_from_io       = 1'b0;
    bus.output_data_from_io      = '0;
    bus.flush_from_pnl           = 1'b0;

    // Reset values
    tick(); tick(); tick();
    chk("rst_in_ready",  bus.host_in_ready_to_host, 0);
    chk("rst_out_valid", bus.host_out_valid_to_host, 0);
    chk("rst_out_data",  bus.host_out_data_to_host, 0);
    chk("rst_in_rdy",    bus.input_rdy_to_io, 0);
    chk("rst_in_data",   bus.input_data_to_io, 0);
    chk("rst_out_ack",   bus.output_ack_to_io, 0);
    chk("rst_in_level",  bus.in_level_to_pnl, 0);
    chk("rst_out_level", bus.out_level_to_pnl, 0);
    resetn = 1'b1;
    chk("rel_ready_low", bus.host_in_ready_to_host, 0);
    tick();
    chk("rel_ready_high", bus.host_in_ready_to_host, 1);

    // Single code, two-cycle latency
    host_push(5'b10011);
    chk("t1_level1", bus.in_level_to_pnl, 1);
    chk("t1_rdy_early", bus.input_rdy_to_io, 0);
    tick();
    chk("t1_rdy", bus.input_rdy_to_io, 1);
    chk("t1_data", bus.input_data_to_io, 5'b10011);
    chk("t1_level0", bus.in_level_to_pnl, 0);
    bus.input_ack_from_io = 1'b1;
    tick();
    chk("t1_rdy_drop", bus.input_rdy_to_io, 0);
    bus.input_ack_from_io = 1'b0;
    tick();
    chk("t1_idle", bus.input_rdy_to_io, 0);

    // Five codes, no ack: one held, four queued
    bus.host_in_valid_from_host = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.host_in_data_from_host = in_codes[i];
      tick();
    end
    bus.host_in_valid_from_host = 1'b0;
    chk("t2_level4", bus.in_level_to_pnl, 4);
    chk("t2_full", bus.host_in_ready_to_host, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t2_rdy", bus.input_rdy_to_io, 1);
      chk("t2_data", bus.input_data_to_io, in_codes[i]);
      bus.input_ack_from_io = 1'b1;
      tick();
      chk("t2_rdy_drop", bus.input_rdy_to_io, 0);
      bus.input_ack_from_io = 1'b0;
      tick();
      if (i < 4) tick();
    end
    tick();
    chk("t2_done_rdy", bus.input_rdy_to_io, 0);
    chk("t2_done_level", bus.in_level_to_pnl, 0);

    // Output path with host stalled: fifth code waits for space
    for (int i = 0; i < 4; i++) begin
      io_send(out_codes[i], 1'b1);
      bus.output_rdy_from_io = 1'b0;
      tick();
      chk("t3_ack_drop", bus.output_ack_to_io, 0);
    end
    chk("t3_level4", bus.out_level_to_pnl, 4);
    io_send(out_codes[4], 1'b0);
    tick();
    chk("t3_stall", bus.output_ack_to_io, 0);
    host_pop("t3_pop0", out_codes[0]);
    chk("t3_stall_pop", bus.output_ack_to_io, 0);
    chk("t3_level3", bus.out_level_to_pnl, 3);
    tick();
    chk("t3_late_ack", bus.output_ack_to_io, 1);
    chk("t3_level4b", bus.out_level_to_pnl, 4);
    bus.output_rdy_from_io = 1'b0;
    tick();
    for (int i = 1; i < 5; i++) host_pop("t3_order", out_codes[i]);
    for (int i = 5; i < 8; i++) begin
      io_send(out_codes[i], 1'b1);
      bus.output_rdy_from_io = 1'b0;
      tick();
    end
    for (int i = 5; i < 8; i++) host_pop("t3_order2", out_codes[i]);
    chk("t3_empty", bus.host_out_valid_to_host, 0);

    // Both channels in the same cycles
    bus.host_in_valid_from_host = 1'b1;
    bus.host_in_data_from_host  = 5'h13;
    bus.output_rdy_from_io      = 1'b1;
    bus.output_data_from_io     = 5'h0C;
    tick();
    bus.host_in_valid_from_host = 1'b0;
    chk("t4_ack", bus.output_ack_to_io, 1);
    bus.output_rdy_from_io = 1'b0;
    tick();
    chk("t4_rdy", bus.input_rdy_to_io, 1);
    chk("t4_data", bus.input_data_to_io, 5'h13);
    chk("t4_ack_drop", bus.output_ack_to_io, 0);
    bus.input_ack_from_io   = 1'b1;
    bus.output_rdy_from_io  = 1'b1;
    bus.output_data_from_io = 5'h0D;
    tick();
    chk("t4_rdy_drop", bus.input_rdy_to_io, 0);
    chk("t4_ack2", bus.output_ack_to_io, 1);
    bus.input_ack_from_io  = 1'b0;
    bus.output_rdy_from_io = 1'b0;
    tick();
    host_pop("t4_out0", 5'h0C);
    host_pop("t4_out1", 5'h0D);

    // Flush during TX_RDY with three queued
    n = 0;
    while (bus.host_in_ready_to_host !== 1'b1 || bus.input_rdy_to_io !== 1'b0 || n < 20) begin
      tick();
      n++;
      if (n > 60) break;
    end
    for (int i = 0; i < 4; i++) host_push(5'h11 + 5'(i));
    chk("t5_level3", bus.in_level_to_pnl, 3);
    chk("t5_rdy", bus.input_rdy_to_io, 1);
    bus.flush_from_pnl = 1'b1;
    tick();
    bus.flush_from_pnl = 1'b0;
    chk("t5_flushed", bus.in_level_to_pnl, 0);
    chk("t5_hold_rdy", bus.input_rdy_to_io, 1);
    chk("t5_hold_data", bus.input_data_to_io, 5'h11);
    bus.input_ack_from_io = 1'b1;
    tick();
    bus.input_ack_from_io = 1'b0;
    tick(); tick(); tick();
    chk("t5_no_more", bus.input_rdy_to_io, 0);
    bus.flush_from_pnl = 1'b1;
    io_send(5'h09, 1'b1);
    bus.flush_from_pnl = 1'b0;
    chk("t5_rx_dropped", bus.out_level_to_pnl, 0);
    bus.output_rdy_from_io = 1'b0;
    tick();
    chk("t5_rx_idle", bus.output_ack_to_io, 0);

    // Ack high in idle blocks the offer; then measure the inter-character gap
    n = 0;
    while (n < 20) begin tick(); n++; end
    bus.input_ack_from_io = 1'b1;
    host_push(5'h1A);
    host_push(5'h1B);
    tick();
    chk("t6_blocked", bus.input_rdy_to_io, 0);
    chk("t6_level2", bus.in_level_to_pnl, 2);
    bus.input_ack_from_io = 1'b0;
    tick();
    chk("t6_rdy", bus.input_rdy_to_io, 1);
    chk("t6_data", bus.input_data_to_io, 5'h1A);
    bus.input_ack_from_io = 1'b1;
    tick();
    bus.input_ack_from_io = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.input_rdy_to_io !== 1'b1 && n < 60);
    chk("t6_tx_gap", 32'(n), 32'(2 + PACE_EXTRA));
    chk("t6_data2", bus.input_data_to_io, 5'h1B);
    bus.input_ack_from_io = 1'b1;
    tick();
    bus.input_ack_from_io = 1'b0;
    tick();
    io_send(5'h02, 1'b1);
    bus.output_rdy_from_io = 1'b0;
    tick();
    bus.output_rdy_from_io  = 1'b1;
    bus.output_data_from_io = 5'h03;
    n = 0;
    do begin tick(); n++; end while (bus.output_ack_to_io !== 1'b1 && n < 60);
    chk("t6_rx_gap", 32'(n), 32'(1 + PACE_EXTRA));
    bus.output_rdy_from_io = 1'b0;
    tick();
    host_pop("t6_out0", 5'h02);
    host_pop("t6_out1", 5'h03);

    // Reset in the middle of a handshake
    host_push(5'h1C);
    n = 0;
    while (bus.input_rdy_to_io !== 1'b1 && n < 60) begin tick(); n++; end
    chk("t7_rdy", bus.input_rdy_to_io, 1);
    resetn = 1'b0;
    tick();
    chk("t7_rst_rdy", bus.input_rdy_to_io, 0);
    chk("t7_rst_ready", bus.host_in_ready_to_host, 0);
    chk("t7_rst_data", bus.input_data_to_io, 0);
    resetn = 1'b1;
    tick(); tick();
    chk("t7_after_rdy", bus.input_rdy_to_io, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
